// File: rtl/hazard_ctrl_unit.sv
// Hazard and forwarding controller for a 5-stage pipeline: operand forwarding muxes,
// a load-use stall FSM, branch flush, data-memory freeze and saturating event counters.
module hazard_ctrl_unit #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int NUM_SRC    = 2,
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC-1:0]        src_used,
    input  logic [NUM_SRC*DATA_W-1:0] src_data_id,
    input  logic [ADDR_W-1:0]         dst_ex,
    input  logic [ADDR_W-1:0]         dst_mem,
    input  logic [ADDR_W-1:0]         dst_wb,
    input  logic                      regwrite_ex,
    input  logic                      regwrite_mem,
    input  logic                      regwrite_wb,
    input  logic                      memread_ex,
    input  logic [DATA_W-1:0]         alu_out_ex,
    input  logic [DATA_W-1:0]         mem_data,
    input  logic [DATA_W-1:0]         wb_out,
    input  logic                      branch_taken_ex,
    input  logic                      mem_busy,
    input  logic                      cnt_clr,
    output logic [NUM_SRC*DATA_W-1:0] src_fwd,
    output logic                      stall_if,
    output logic                      stall_id,
    output logic                      bubble_ex,
    output logic                      flush_id,
    output logic                      freeze,
    output logic [CNT_W-1:0]          lu_stall_cnt,
    output logic [CNT_W-1:0]          freeze_cnt,
    output logic [CNT_W-1:0]          flush_cnt
);

    typedef enum logic {ST_RUN, ST_LU2} state_t;

    state_t              r_state;
    logic                r_hold_valid;
    logic [ADDR_W-1:0]   r_hold_dst;
    logic [DATA_W-1:0]   r_hold_data;
    logic [CNT_W-1:0]    r_lu_cnt;
    logic [CNT_W-1:0]    r_frz_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    logic [NUM_SRC-1:0]  w_lu_vec;
    logic                w_lu;
    logic                w_freeze;
    logic                w_flush;
    logic                w_lu_stall;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        logic [ADDR_W-1:0] w_addr;
        logic              w_nz;
        logic              w_hit_ex;
        logic              w_hit_mem;
        logic              w_hit_wb;
        logic              w_hit_hold;

        assign w_addr     = src_addr[g*ADDR_W +: ADDR_W];
        assign w_nz       = (w_addr != '0);
        // A load in EX has no data yet, so it never forwards; it stalls instead.
        assign w_hit_ex   = w_nz && regwrite_ex && !memread_ex && (w_addr == dst_ex);
        assign w_hit_mem  = w_nz && regwrite_mem && (w_addr == dst_mem);
        assign w_hit_wb   = w_nz && regwrite_wb && (w_addr == dst_wb);
        assign w_hit_hold = w_nz && r_hold_valid && (w_addr == r_hold_dst);

        assign src_fwd[g*DATA_W +: DATA_W] =
            w_hit_ex   ? alu_out_ex  :
            w_hit_mem  ? mem_data    :
            w_hit_wb   ? wb_out      :
            w_hit_hold ? r_hold_data :
                         src_data_id[g*DATA_W +: DATA_W];

        assign w_lu_vec[g] = src_used[g] && w_nz && regwrite_ex && memread_ex &&
                             (w_addr == dst_ex);
    end

    assign w_lu = |w_lu_vec;

    // Priority decode: freeze beats flush beats load-use.
    assign w_freeze   = mem_busy;
    assign w_flush    = !mem_busy && branch_taken_ex;
    assign w_lu_stall = !mem_busy && !branch_taken_ex && ((r_state == ST_LU2) || w_lu);

    // NOTE: every output is assigned on every path of this always_comb, so no latch is inferred.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        bubble_ex = 1'b0;
        flush_id  = 1'b0;
        freeze    = 1'b0;
        if (rst_n) begin
            if (w_freeze) begin
                freeze   = 1'b1;
                stall_if = 1'b1;
                stall_id = 1'b1;
            end else if (w_flush) begin
                flush_id  = 1'b1;
                bubble_ex = 1'b1;
            end else if (w_lu_stall) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_hold_valid <= 1'b0;
            r_hold_dst   <= '0;
            r_hold_data  <= '0;
            r_lu_cnt     <= '0;
            r_frz_cnt    <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (!mem_busy) begin
                r_hold_valid <= regwrite_wb && (dst_wb != '0);
                r_hold_dst   <= dst_wb;
                r_hold_data  <= wb_out;
                if (branch_taken_ex || (r_state == ST_LU2)) begin
                    r_state <= ST_RUN;
                end else if (w_lu && (LU_BUBBLES == 2)) begin
                    r_state <= ST_LU2;
                end
            end

            if (cnt_clr) begin
                r_lu_cnt    <= '0;
                r_frz_cnt   <= '0;
                r_flush_cnt <= '0;
            end else begin
                if (w_freeze && (r_frz_cnt != '1))
                    r_frz_cnt <= r_frz_cnt + 1'b1;
                if (w_flush && (r_flush_cnt != '1))
                    r_flush_cnt <= r_flush_cnt + 1'b1;
                if (w_lu_stall && (r_lu_cnt != '1))
                    r_lu_cnt <= r_lu_cnt + 1'b1;
            end
        end
    end

    assign lu_stall_cnt = r_lu_cnt;
    assign freeze_cnt   = r_frz_cnt;
    assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: one instance with 1 load-use bubble and 4-bit
// counters, one with 2 bubbles and 16-bit counters, both driven by the same stimulus.
module tb_hazard_ctrl_unit;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NS = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NS*AW-1:0] src_addr;
    logic [NS-1:0]    src_used;
    logic [NS*DW-1:0] src_data_id;
    logic [AW-1:0]    dst_ex, dst_mem, dst_wb;
    logic             regwrite_ex, regwrite_mem, regwrite_wb, memread_ex;
    logic [DW-1:0]    alu_out_ex, mem_data, wb_out;
    logic             branch_taken_ex, mem_busy, cnt_clr;

    logic [NS*DW-1:0] a_src_fwd, b_src_fwd;
    logic             a_stall_if, a_stall_id, a_bubble_ex, a_flush_id, a_freeze;
    logic             b_stall_if, b_stall_id, b_bubble_ex, b_flush_id, b_freeze;
    logic [3:0]       a_lu_cnt, a_frz_cnt, a_fl_cnt;
    logic [15:0]      b_lu_cnt, b_frz_cnt, b_fl_cnt;
    logic [4:0]       a_ctrl, b_ctrl;

    // Control bundle order: {stall_if, stall_id, bubble_ex, flush_id, freeze}
    assign a_ctrl = {a_stall_if, a_stall_id, a_bubble_ex, a_flush_id, a_freeze};
    assign b_ctrl = {b_stall_if, b_stall_id, b_bubble_ex, b_flush_id, b_freeze};

    hazard_ctrl_unit #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(NS), .LU_BUBBLES(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .src_addr(src_addr), .src_used(src_used),
        .src_data_id(src_data_id), .dst_ex(dst_ex), .dst_mem(dst_mem), .dst_wb(dst_wb),
        .regwrite_ex(regwrite_ex), .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb),
        .memread_ex(memread_ex), .alu_out_ex(alu_out_ex), .mem_data(mem_data), .wb_out(wb_out),
        .branch_taken_ex(branch_taken_ex), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
        .src_fwd(a_src_fwd), .stall_if(a_stall_if), .stall_id(a_stall_id),
        .bubble_ex(a_bubble_ex), .flush_id(a_flush_id), .freeze(a_freeze),
        .lu_stall_cnt(a_lu_cnt), .freeze_cnt(a_frz_cnt), .flush_cnt(a_fl_cnt)
    );

    hazard_ctrl_unit #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(NS), .LU_BUBBLES(2), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .src_addr(src_addr), .src_used(src_used),
        .src_data_id(src_data_id), .dst_ex(dst_ex), .dst_mem(dst_mem), .dst_wb(dst_wb),
        .regwrite_ex(regwrite_ex), .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb),
        .memread_ex(memread_ex), .alu_out_ex(alu_out_ex), .mem_data(mem_data), .wb_out(wb_out),
        .branch_taken_ex(branch_taken_ex), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
        .src_fwd(b_src_fwd), .stall_if(b_stall_if), .stall_id(b_stall_id),
        .bubble_ex(b_bubble_ex), .flush_id(b_flush_id), .freeze(b_freeze),
        .lu_stall_cnt(b_lu_cnt), .freeze_cnt(b_frz_cnt), .flush_cnt(b_fl_cnt)
    );

    typedef struct {
        string       name;
        logic [4:0]  a0, a1;
        logic [1:0]  used;
        logic [4:0]  dex, dmem, dwb;
        logic        rwex, rwmem, rwwb, mrex;
        logic [31:0] wbd;
        logic [31:0] f0, f1;
        logic        stall;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] f0, f1;
        logic        stall;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [4:0] a0, input logic [4:0] a1,
                                input logic [1:0] used, input logic [4:0] dex,
                                input logic [4:0] dmem, input logic [4:0] dwb,
                                input logic rwex, input logic rwmem, input logic rwwb,
                                input logic mrex, input logic [31:0] wbd,
                                input logic [31:0] f0, input logic [31:0] f1,
                                input logic stall);
        vec_t v;
        v.name = name; v.a0 = a0; v.a1 = a1; v.used = used;
        v.dex = dex; v.dmem = dmem; v.dwb = dwb;
        v.rwex = rwex; v.rwmem = rwmem; v.rwwb = rwwb; v.mrex = mrex;
        v.wbd = wbd; v.f0 = f0; v.f1 = f1; v.stall = stall;
        return v;
    endfunction

    task automatic idle();
        src_addr        = '0;
        src_used        = '0;
        src_data_id     = {32'hD1, 32'hD0};
        dst_ex          = '0;
        dst_mem         = '0;
        dst_wb          = '0;
        regwrite_ex     = 1'b0;
        regwrite_mem    = 1'b0;
        regwrite_wb     = 1'b0;
        memread_ex      = 1'b0;
        alu_out_ex      = 32'hA;
        mem_data        = 32'hB;
        wb_out          = 32'h0;
        branch_taken_ex = 1'b0;
        mem_busy        = 1'b0;
        cnt_clr         = 1'b0;
    endtask

    task automatic set_src(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] used);
        src_addr = {a1, a0};
        src_used = used;
    endtask

    // Load in EX writing r4, ID instruction reads r4 on source 0.
    task automatic lu_inputs();
        regwrite_ex = 1'b1;
        memread_ex  = 1'b1;
        dst_ex      = 5'd4;
        set_src(5'd4, 5'd0, 2'b01);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int stall_cycles;

    initial begin
        // name, a0, a1, used, dex, dmem, dwb, rwex, rwmem, rwwb, mrex, wb_out, exp f0, exp f1, exp stall
        vecs.push_back(mk("ex_pri",       3, 0, 2'b11, 3, 3, 0, 1,1,0,0, 32'h0,  32'hA,  32'hD1, 0));
        vecs.push_back(mk("mem_pri",      3, 0, 2'b11, 3, 3, 0, 0,1,0,0, 32'h0,  32'hB,  32'hD1, 0));
        vecs.push_back(mk("zero_addr",    0, 0, 2'b11, 0, 0, 0, 1,1,1,0, 32'hC,  32'hD0, 32'hD1, 0));
        vecs.push_back(mk("wb_r7",        5, 6, 2'b11, 1, 2, 7, 1,1,1,0, 32'h55, 32'hD0, 32'hD1, 0));
        vecs.push_back(mk("hold_fwd",     0, 7, 2'b11, 1, 2, 9, 1,1,1,0, 32'h66, 32'hD0, 32'h55, 0));
        vecs.push_back(mk("wb_over_hold", 9, 9, 2'b11, 1, 2, 9, 1,1,1,0, 32'h77, 32'h77, 32'h77, 0));
        vecs.push_back(mk("hold_dst0",    9, 0, 2'b11, 1, 2, 0, 1,1,1,0, 32'h88, 32'h77, 32'hD1, 0));
        vecs.push_back(mk("hold_cleared", 9, 0, 2'b11, 0, 0, 7, 0,0,0,0, 32'h99, 32'hD0, 32'hD1, 0));
        vecs.push_back(mk("hold_nowrite", 0, 7, 2'b11, 0, 0, 0, 0,0,0,0, 32'h0,  32'hD0, 32'hD1, 0));
        vecs.push_back(mk("mem_vs_wb",   12,12, 2'b11, 1,12,12, 0,1,1,0, 32'hC,  32'hB,  32'hB,  0));
        vecs.push_back(mk("load_unused", 13, 0, 2'b00,13,13, 0, 1,1,0,1, 32'h0,  32'hB,  32'hD1, 0));
        vecs.push_back(mk("load_src1_nu", 0,13, 2'b01,13, 0, 0, 1,0,0,1, 32'h0,  32'hD0, 32'hD1, 0));

        // Reset: control outputs forced low even with freeze/flush inputs active.
        idle();
        rst_n           = 1'b0;
        mem_busy        = 1'b1;
        branch_taken_ex = 1'b1;
        @(negedge clk);
        check("rst_ctrl_a", a_ctrl, 5'b0);
        check("rst_ctrl_b", b_ctrl, 5'b0);
        check("rst_cnt_a", {a_lu_cnt, a_frz_cnt, a_fl_cnt}, 12'h0);
        check("rst_cnt_b", {b_lu_cnt, b_frz_cnt, b_fl_cnt}, 48'h0);
        step();
        idle();
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ctrl_a", a_ctrl, 5'b0);
        check("idle_fwd_a", a_src_fwd, {32'hD1, 32'hD0});

        // Forwarding table through the scoreboard.
        foreach (vecs[k]) begin
            exp_t e;
            step();
            idle();
            set_src(vecs[k].a0, vecs[k].a1, vecs[k].used);
            dst_ex = vecs[k].dex; dst_mem = vecs[k].dmem; dst_wb = vecs[k].dwb;
            regwrite_ex = vecs[k].rwex; regwrite_mem = vecs[k].rwmem;
            regwrite_wb = vecs[k].rwwb; memread_ex = vecs[k].mrex;
            wb_out = vecs[k].wbd;
            e.name = vecs[k].name; e.f0 = vecs[k].f0; e.f1 = vecs[k].f1; e.stall = vecs[k].stall;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            check({e.name, "_f0"}, a_src_fwd[31:0], e.f0);
            check({e.name, "_f1"}, a_src_fwd[63:32], e.f1);
            check({e.name, "_stall"}, a_stall_id, e.stall);
        end

        // Load-use: 1 bubble then MEM data; 2 bubbles then WB data.
        step(); idle(); cnt_clr = 1'b1;
        step(); idle(); lu_inputs();
        @(negedge clk);
        check("lu_c0_a", a_ctrl, 5'b11100);
        check("lu_c0_b", b_ctrl, 5'b11100);
        step(); idle(); set_src(5'd4, 5'd0, 2'b01); dst_mem = 5'd4; regwrite_mem = 1'b1;
        @(negedge clk);
        check("lu_c1_a", a_ctrl, 5'b0);
        check("lu_c1_fwd_a", a_src_fwd[31:0], 32'hB);
        check("lu_c1_b", b_ctrl, 5'b11100);
        check("lu_cnt_a1", a_lu_cnt, 4'd1);
        step(); idle(); set_src(5'd4, 5'd0, 2'b01); dst_wb = 5'd4; regwrite_wb = 1'b1;
        wb_out = 32'h44;
        @(negedge clk);
        check("lu_c2_b", b_ctrl, 5'b0);
        check("lu_c2_fwd_b", b_src_fwd[31:0], 32'h44);
        check("lu_cnt_a2", a_lu_cnt, 4'd1);
        check("lu_cnt_b2", b_lu_cnt, 16'd2);
        step(); idle(); lu_inputs(); src_used = 2'b00;
        @(negedge clk);
        check("lu_unused_a", a_ctrl, 5'b0);
        check("lu_unused_b", b_ctrl, 5'b0);

        // 2-bubble load-use stretched by a 3-cycle freeze in LU2; HOLD must not move.
        step(); idle(); cnt_clr = 1'b1;
        stall_cycles = 0;
        step(); idle(); lu_inputs(); dst_wb = 5'd20; regwrite_wb = 1'b1; wb_out = 32'h20;
        @(negedge clk);
        check("frz_c0_b", b_ctrl, 5'b11100);
        stall_cycles += int'(b_stall_id);
        for (int c = 1; c <= 3; c++) begin
            step(); idle(); set_src(5'd4, 5'd0, 2'b01); mem_busy = 1'b1;
            dst_mem = 5'd4; regwrite_mem = 1'b1;
            dst_wb = 5'd21; regwrite_wb = 1'b1; wb_out = 32'h21;
            @(negedge clk);
            check($sformatf("frz_c%0d_b", c), b_ctrl, 5'b11001);
            stall_cycles += int'(b_stall_id);
        end
        step(); idle(); set_src(5'd4, 5'd20, 2'b01); dst_mem = 5'd4; regwrite_mem = 1'b1;
        @(negedge clk);
        check("frz_c4_b", b_ctrl, 5'b11100);
        check("frz_c4_a", a_ctrl, 5'b0);
        check("frz_c4_fwd0", b_src_fwd[31:0], 32'hB);
        check("frz_hold_kept", b_src_fwd[63:32], 32'h20);
        stall_cycles += int'(b_stall_id);
        step(); idle();
        @(negedge clk);
        check("frz_c5_b", b_ctrl, 5'b0);
        stall_cycles += int'(b_stall_id);
        check("frz_stall_cycles", stall_cycles, 5);
        check("frz_lu_cnt_b", b_lu_cnt, 16'd2);
        check("frz_frz_cnt_b", b_frz_cnt, 16'd3);
        check("frz_frz_cnt_a", a_frz_cnt, 4'd3);
        check("frz_lu_cnt_a", a_lu_cnt, 4'd1);

        // Flush beats load-use; freeze beats flush.
        step(); idle(); cnt_clr = 1'b1;
        step(); idle(); lu_inputs(); branch_taken_ex = 1'b1;
        @(negedge clk);
        check("fl_c0_a", a_ctrl, 5'b00110);
        check("fl_c0_b", b_ctrl, 5'b00110);
        step(); idle(); lu_inputs(); branch_taken_ex = 1'b1; mem_busy = 1'b1;
        @(negedge clk);
        check("fl_c1_a", a_ctrl, 5'b11001);
        step(); idle();
        @(negedge clk);
        check("fl_c2_b", b_ctrl, 5'b0);
        check("fl_cnt_a", a_fl_cnt, 4'd1);
        check("fl_frz_cnt_a", a_frz_cnt, 4'd1);
        check("fl_lu_cnt_a", a_lu_cnt, 4'd0);
        // Branch arriving in LU2 flushes and returns to RUN.
        step(); idle(); lu_inputs();
        @(negedge clk);
        check("lu2br_c0_b", b_ctrl, 5'b11100);
        step(); idle(); branch_taken_ex = 1'b1;
        @(negedge clk);
        check("lu2br_c1_b", b_ctrl, 5'b00110);
        step(); idle();
        @(negedge clk);
        check("lu2br_c2_b", b_ctrl, 5'b0);
        check("lu2br_fl_cnt_b", b_fl_cnt, 16'd2);
        check("lu2br_lu_cnt_b", b_lu_cnt, 16'd1);

        // Saturation of the 4-bit counter, then clear colliding with an increment.
        for (int c = 0; c < 20; c++) begin
            step(); idle(); mem_busy = 1'b1;
        end
        step(); idle();
        @(negedge clk);
        check("sat_frz_a", a_frz_cnt, 4'hF);
        check("sat_frz_b", b_frz_cnt, 16'd21);
        step(); idle(); mem_busy = 1'b1; cnt_clr = 1'b1;
        step(); idle();
        @(negedge clk);
        check("clr_cnt_a", {a_lu_cnt, a_frz_cnt, a_fl_cnt}, 12'h0);
        check("clr_cnt_b", {b_lu_cnt, b_frz_cnt, b_fl_cnt}, 48'h0);

        // Reset asserted while in LU2.
        step(); idle(); lu_inputs();
        @(negedge clk);
        check("rstlu2_c0_b", b_ctrl, 5'b11100);
        step(); idle(); lu_inputs(); rst_n = 1'b0;
        @(negedge clk);
        check("rstlu2_forced_b", b_ctrl, 5'b0);
        check("rstlu2_cnt_b", b_lu_cnt, 16'd0);
        step(); idle(); rst_n = 1'b1;
        @(negedge clk);
        check("rstlu2_run_b", b_ctrl, 5'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
